// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between the instruction
// fetch port and the load/store port. One grant per cycle, data-first fixed
// priority with a fetch starvation guard. Read data returns one cycle after
// grant and is steered to the side recorded in the registered owner field.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration replaces the
// fixed priority and the starvation counter.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_read_en,
  input  logic [1:0]        d_write_en,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_read_en,
  output logic [1:0]        m_write_en,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  owner_t owner, owner_nxt;
  logic   i_elig, d_elig, d_store;
  logic   grant_i, grant_d;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {SIDE_D, SIDE_I} side_t;
  side_t last, last_nxt;
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
`endif

  // A data request with both enables nonzero is treated as a store only.
  assign i_elig  = i_req;
  assign d_elig  = d_req && ((d_read_en != 2'b00) || (d_write_en != 2'b00));
  assign d_store = (d_write_en != 2'b00);

  // Pick at most one winner this cycle; nothing is granted while in reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (i_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
        if (last == SIDE_I) grant_d = 1'b1;
        else                grant_i = 1'b1;
`else
        if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
        else                          grant_d = 1'b1;
`endif
      end else if (d_elig) begin
        grant_d = 1'b1;
      end else if (i_elig) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  // Route the winner's address, enables and store data to the RAM lanes.
  always_comb begin
    m_addr     = '0;
    m_read_en  = 2'b00;
    m_write_en = 2'b00;
    m_wdata    = '0;
    if (grant_i) begin
      m_addr    = i_addr;
      m_read_en = 2'b11;
    end else if (grant_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      if (d_store) m_write_en = d_write_en;
      else         m_read_en  = d_read_en;
    end
  end

  // Response owner for next cycle: set on read grants, cleared otherwise.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (grant_i)                owner_nxt = OWN_I;
    else if (grant_d && !d_store) owner_nxt = OWN_D;
  end

  // Owner register; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) owner <= OWN_NONE;
    else     owner <= owner_nxt;
  end

`ifdef MEM_ARB_RR_EN
  // Remember which side was granted last; idle cycles keep the old value.
  always_comb begin
    last_nxt = last;
    if (grant_i)      last_nxt = SIDE_I;
    else if (grant_d) last_nxt = SIDE_D;
  end

  // Last-granted register; starts at I so data wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) last <= SIDE_I;
    else     last <= last_nxt;
  end
`else
  // Count consecutive data grants while fetch waits, saturating at the limit.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!i_req || grant_i) starve_cnt_nxt = '0;
    else if (grant_d && (starve_cnt != STARVE_LIM)) starve_cnt_nxt = starve_cnt + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= '0;
    else     starve_cnt <= starve_cnt_nxt;
  end
`endif

  // Response stage: the owner sees the RAM output, everyone else sees zero.
  assign i_valid = !rst && (owner == OWN_I);
  assign d_valid = !rst && (owner == OWN_D);
  assign i_rdata = i_valid ? m_rdata : '0;
  assign d_rdata = d_valid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level reference model.
// Honors MEM_ARB_RR_EN the same way the design does.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [1:0]    d_read_en, d_write_en;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_valid, d_gnt, d_valid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_read_en, m_write_en;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_read_en(d_read_en), .d_write_en(d_write_en),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_read_en(m_read_en), .m_write_en(m_write_en),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: write at the edge, read data next cycle.
  logic [DW-1:0] mem [0:1023] = '{default: '0};
  always @(posedge clk) begin
    if (m_write_en != 2'b00) mem[m_addr[9:0]] <= m_wdata;
    m_rdata <= (m_read_en != 2'b00) ? mem[m_addr[9:0]] : '0;
  end

  // Reference model state (win/owner codes: 0 none, 1 fetch, 2 data).
  logic [DW-1:0] mmem [0:1023] = '{default: '0};
  int            ms_cnt, ms_owner, ms_last;
  logic [DW-1:0] ms_data;
  int            g_win;
  logic          o_i_gnt, o_d_gnt, o_i_valid, o_d_valid;
  logic [DW-1:0] o_i_rdata, o_d_rdata;
  logic [1:0]    o_m_read_en;
  int            ncmp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the arbitration rules, compare, advance model.
  task automatic step();
    int            win;
    bit            ie, de, dst;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_re, e_we;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    ie  = i_req;
    de  = d_req && ((d_read_en != 2'b00) || (d_write_en != 2'b00));
    dst = (d_write_en != 2'b00);
    win = 0;
    if (!rst) begin
      if (ie && de) begin
`ifdef MEM_ARB_RR_EN
        win = (ms_last == 1) ? 2 : 1;
`else
        win = (ms_cnt == SMAX) ? 1 : 2;
`endif
      end else if (de) win = 2;
      else if (ie) win = 1;
    end
    e_addr = '0; e_re = 2'b00; e_we = 2'b00; e_wd = '0;
    if (win == 1) begin
      e_addr = i_addr; e_re = 2'b11;
    end else if (win == 2) begin
      e_addr = d_addr; e_wd = d_wdata;
      if (dst) e_we = d_write_en; else e_re = d_read_en;
    end
    chk("i_gnt", i_gnt, win == 1);
    chk("d_gnt", d_gnt, win == 2);
    chk("m_addr", m_addr, e_addr);
    chk("m_read_en", m_read_en, e_re);
    chk("m_write_en", m_write_en, e_we);
    chk("m_wdata", m_wdata, e_wd);
    chk("i_valid", i_valid, !rst && ms_owner == 1);
    chk("d_valid", d_valid, !rst && ms_owner == 2);
    chk("i_rdata", i_rdata, (!rst && ms_owner == 1) ? ms_data : '0);
    chk("d_rdata", d_rdata, (!rst && ms_owner == 2) ? ms_data : '0);
    o_i_gnt = i_gnt; o_d_gnt = d_gnt; o_i_valid = i_valid; o_d_valid = d_valid;
    o_i_rdata = i_rdata; o_d_rdata = d_rdata; o_m_read_en = m_read_en;
    g_win = win;
    if (rst) begin
      ms_cnt = 0; ms_owner = 0; ms_last = 1;
    end else begin
      if (win == 1) ms_data = mmem[i_addr[9:0]];
      if (win == 2 && !dst) ms_data = mmem[d_addr[9:0]];
      if (win == 2 && dst) mmem[d_addr[9:0]] = d_wdata;
      ms_owner = (win == 1) ? 1 : ((win == 2 && !dst) ? 2 : 0);
      if (!i_req || win == 1) ms_cnt = 0;
      else if (win == 2 && ms_cnt < SMAX) ms_cnt++;
      if (win != 0) ms_last = win;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input bit req, input logic [AW-1:0] a, input logic [1:0] re,
                         input logic [1:0] we, input logic [DW-1:0] wd);
    d_req = req; d_addr = a; d_read_en = re; d_write_en = we; d_wdata = wd;
  endtask

  initial begin
    int seq_exp[$];
    bit i_pend, d_pend;
    int kind;
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    drive_d(1'b0, '0, 2'b00, 2'b00, '0);
    ms_cnt = 0; ms_owner = 0; ms_last = 1; ms_data = '0; g_win = 0;
    @(posedge clk); #1;

    // Reset held two cycles with both sides requesting: everything is zero.
    i_req = 1'b1; i_addr = 32'h20;
    drive_d(1'b1, 32'h24, 2'b11, 2'b00, 32'h0);
    repeat (2) begin
      step();
      chk("rst_gnt", {o_i_gnt, o_d_gnt}, 2'b00);
      chk("rst_valid", {o_i_valid, o_d_valid}, 2'b00);
    end
    rst = 1'b0;

    // Continuous contention from release.
`ifdef MEM_ARB_RR_EN
    seq_exp = '{2, 1, 2, 1, 2, 1};
`else
    seq_exp = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
`endif
    foreach (seq_exp[k]) begin
      step();
      chk("contend_seq", g_win, seq_exp[k]);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Program word via a store, then fetch it.
    drive_d(1'b1, 32'h10, 2'b00, 2'b11, 32'h0050_0093);
    step();
    chk("prog_store_gnt", o_d_gnt, 1'b1);
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    step();
    chk("fetch_gnt", o_i_gnt, 1'b1);
    chk("fetch_re", o_m_read_en, 2'b11);
    i_req = 1'b0;
    step();
    chk("fetch_valid", o_i_valid, 1'b1);
    chk("fetch_rdata", o_i_rdata, 32'h0050_0093);

    // Store then load of the same word.
    drive_d(1'b1, 32'h100, 2'b00, 2'b11, 32'hDEAD_BEEF);
    step();
    chk("store_gnt", o_d_gnt, 1'b1);
    drive_d(1'b1, 32'h100, 2'b11, 2'b00, 32'h0);
    step();
    chk("store_no_valid", o_d_valid, 1'b0);
    chk("load_gnt", o_d_gnt, 1'b1);
    d_req = 1'b0;
    step();
    chk("load_valid", o_d_valid, 1'b1);
    chk("load_rdata", o_d_rdata, 32'hDEAD_BEEF);

    // Reset right after a load grant cancels its response.
    drive_d(1'b1, 32'h100, 2'b11, 2'b00, 32'h0);
    step();
    chk("midrst_load_gnt", o_d_gnt, 1'b1);
    d_req = 1'b0; rst = 1'b1;
    step();
    chk("midrst_valid_n1", o_d_valid, 1'b0);
    rst = 1'b0;
    step();
    chk("midrst_valid_n2", o_d_valid, 1'b0);

    // Data alone is granted every cycle.
    for (int k = 0; k < 5; k++) begin
      drive_d(1'b1, AW'($urandom_range(0, 1023)), 2'b11, 2'b00, 32'h0);
      step();
      chk("d_only_gnt", o_d_gnt, 1'b1);
    end
    d_req = 1'b0;

    // Randomized traffic obeying the hold-until-grant handshake.
    i_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!i_pend || g_win == 1) begin
        i_pend = ($urandom_range(0, 2) != 0);
        i_req  = i_pend;
        i_addr = AW'($urandom_range(0, 1023));
      end
      if (!d_pend || g_win == 2) begin
        kind = int'($urandom_range(0, 4));
        case (kind)
          0, 1:    drive_d(1'b1, AW'($urandom_range(0, 1023)), 2'($urandom_range(1, 3)), 2'b00, $urandom);
          2:       drive_d(1'b1, AW'($urandom_range(0, 1023)), 2'b00, 2'($urandom_range(1, 3)), $urandom);
          3:       drive_d(1'b1, AW'($urandom_range(0, 1023)), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), $urandom);
          default: drive_d(($urandom_range(0, 1) == 1), AW'($urandom_range(0, 1023)), 2'b00, 2'b00, $urandom);
        endcase
        d_pend = (kind < 4);
      end
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
